// File: rtl/sd_cmd_phy.sv
// SD host command-line PHY: serialises a 48-bit command frame with CRC7 on CMD,
// then captures and checks the 48-bit short response and hands it back.
module sd_cmd_phy #(
  parameter int NCR_MAX = 64,
  parameter int CNT_W   = 7
) (
  input  logic        iClock_host,
  input  logic        iReset,
  input  logic        iStrobe_in,
  input  logic [5:0]  iCmd_index,
  input  logic [31:0] iCmd_argument,
  input  logic        iNo_response,
  input  logic        iAck_in,
  input  logic        iCmd_in,
  output logic        oAck_out,
  output logic        oStrobe_out,
  output logic [37:0] oResponse,
  output logic        oCrc_error,
  output logic        oTimeout,
  output logic        oCmd_out,
  output logic        oCmd_oe,
  output logic        oIdle_out,
  output logic [2:0]  dbg_state
);

  // Handshakes: iStrobe_in/oAck_out and oStrobe_out/iAck_in are four-phase.
  // A request is taken on an IDLE edge with iStrobe_in=1; ack drops on the
  // first edge that sees the strobe low. oStrobe_out holds until an edge with
  // iAck_in=1, and IDLE is re-entered only once iAck_in has returned low.
  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, DONE} state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(38);
  localparam logic [CNT_W-1:0] CRC_FIRST = CNT_W'(39);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(45);
  localparam logic [CNT_W-1:0] END_BIT   = CNT_W'(46);
  localparam logic [CNT_W-1:0] NCR_LAST  = CNT_W'(NCR_MAX - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [38:0]      tx_sr;   // frame bits 46..8 still to be sent
  logic [45:0]      rx_sr;   // response bits 46..1 as they arrive
  logic [6:0]       crc;
  logic             no_resp;
  logic             posted;  // oStrobe_out has been raised in this DONE visit

  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
    crc_step = {c[5:0], 1'b0} ^ ({7{b ^ c[6]}} & 7'h09);
  endfunction

  logic [6:0] crc_tx_next;
  logic [6:0] crc_rx_next;
  logic       rx_bad;

  assign crc_tx_next = crc_step(crc, oCmd_out);
  assign crc_rx_next = crc_step(crc, iCmd_in);
  // Evaluated on the edge that samples the end bit, so iCmd_in is bit 0.
  assign rx_bad      = rx_sr[45] | (rx_sr[6:0] != crc) | ~iCmd_in;
  assign dbg_state   = state;

  always_ff @(posedge iClock_host or posedge iReset) begin
    if (iReset) begin
      state       <= IDLE;
      cnt         <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      crc         <= '0;
      no_resp     <= 1'b0;
      posted      <= 1'b0;
      oAck_out    <= 1'b0;
      oStrobe_out <= 1'b0;
      oResponse   <= '0;
      oCrc_error  <= 1'b0;
      oTimeout    <= 1'b0;
      oCmd_out    <= 1'b1;
      oCmd_oe     <= 1'b0;
      oIdle_out   <= 1'b1;
    end else begin
      if (!iStrobe_in) oAck_out <= 1'b0;
      case (state)
        IDLE: begin
          if (iStrobe_in) begin
            tx_sr      <= {1'b1, iCmd_index, iCmd_argument};
            no_resp    <= iNo_response;
            oCrc_error <= 1'b0;
            oTimeout   <= 1'b0;
            oAck_out   <= 1'b1;
            oCmd_oe    <= 1'b1;
            oCmd_out   <= 1'b0;
            crc        <= '0;
            cnt        <= '0;
            oIdle_out  <= 1'b0;
            state      <= SEND;
          end
        end
        SEND: begin
          // cnt is the cycle index whose bit is currently on the line
          cnt   <= cnt + ONE;
          tx_sr <= {tx_sr[37:0], 1'b0};
          if (cnt <= DATA_LAST) begin
            crc      <= crc_tx_next;
            oCmd_out <= tx_sr[38];
          end else if (cnt == CRC_FIRST) begin
            crc      <= {crc_tx_next[5:0], 1'b0};
            oCmd_out <= crc_tx_next[6];
          end else if (cnt <= CRC_LAST) begin
            crc      <= {crc[5:0], 1'b0};
            oCmd_out <= crc[6];
          end else if (cnt == END_BIT) begin
            oCmd_out <= 1'b1;
          end else begin
            oCmd_oe  <= 1'b0;
            oCmd_out <= 1'b1;
            cnt      <= '0;
            posted   <= 1'b0;
            if (no_resp) begin
              oResponse <= '0;
              state     <= DONE;
            end else begin
              state     <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (!iCmd_in) begin
            rx_sr <= '0;
            crc   <= crc_step(7'd0, iCmd_in);
            cnt   <= '0;
            state <= RECV;
          end else if (cnt == NCR_LAST) begin
            oTimeout  <= 1'b1;
            oResponse <= '0;
            posted    <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        RECV: begin
          // cnt k receives response bit 46-k; CRC covers bits down to 8
          rx_sr <= {rx_sr[44:0], iCmd_in};
          cnt   <= cnt + ONE;
          if (cnt <= DATA_LAST) crc <= crc_rx_next;
          if (cnt == END_BIT) begin
            oResponse  <= rx_sr[44:7];
            oCrc_error <= rx_bad;
            posted     <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (!posted) begin
            oStrobe_out <= 1'b1;
            posted      <= 1'b1;
          end else if (oStrobe_out) begin
            if (iAck_in) oStrobe_out <= 1'b0;
          end else if (!iAck_in) begin
            oIdle_out <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sd_cmd_phy.md
Name: sd_cmd_phy

Overview:
- Command-line physical layer of the SD host; sits directly downstream of the command control block.
- Accepts a command index and argument over a four-phase strobe/ack handshake.
- Builds the 48-bit SD command frame with serial CRC7 and shifts it out on the CMD line, one bit per clock.
- Captures the 48-bit short response (R1/R3/R6/R7 class), checks it, and returns the 38-bit payload to the control block over a second strobe/ack handshake.

Parameters:
- NCR_MAX, 64: maximum cycles waited in WAIT_RESP for the response start bit before declaring timeout.
- CNT_W, 7: width of the bit/wait counter; must hold max(48, NCR_MAX).

Ports:
- iClock_host  in  1  host clock; all state updates on rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iStrobe_in  in  1  control requests transmission; index, argument and iNo_response stable while high.
- iCmd_index  in  6  command index.
- iCmd_argument  in  32  command argument.
- iNo_response  in  1  1 = command expects no response (e.g. CMD0).
- iAck_in  in  1  control has consumed the response.
- iCmd_in  in  1  CMD line input (card drives it during response).
- oAck_out  out  1  command accepted.
- oStrobe_out  out  1  response or status valid.
- oResponse  out  38  {response index[5:0], response argument/status[31:0]}.
- oCrc_error  out  1  response failed its checks; valid with oStrobe_out.
- oTimeout  out  1  no start bit within NCR_MAX cycles; valid with oStrobe_out.
- oCmd_out  out  1  CMD line output data.
- oCmd_oe  out  1  CMD line output enable.
- oIdle_out  out  1  1 in IDLE only.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, oCmd_oe=0, oCmd_out=1, oAck_out=0, oStrobe_out=0, oResponse=0, oCrc_error=0, oTimeout=0, oIdle_out=1.
- Reset mid-transfer aborts the transfer; the CMD line is released in the same cycle.
- States: IDLE, SEND, WAIT_RESP, RECV, DONE.
- IDLE:
  - On an edge with iStrobe_in=1: latch index, argument and iNo_response; clear oCrc_error and oTimeout; oAck_out<=1; go to SEND.
  - On that same edge: oCmd_oe<=1, oCmd_out<=0 (start bit).
- oAck_out, in any state: falls on the first edge with iStrobe_in=0. The transfer does not depend on ack completion.
- SEND:
  - Frame = {0, 1, index[5:0], arg[31:0], crc7[6:0], 1}, MSB first. Frame bit 47-i is on oCmd_out during cycle i after acceptance; 48 cycles total.
  - CRC7 uses polynomial x^7+x^3+1 with init 0, computed serially over frame bits 47..8 as they shift out.
  - On the edge ending the end-bit cycle: oCmd_oe<=0, oCmd_out<=1. Next state is DONE if the latched iNo_response=1, else WAIT_RESP with counter cleared.
- WAIT_RESP:
  - Sample iCmd_in each edge. First 0 sampled = response bit 47; go to RECV with 47 bits remaining.
  - If NCR_MAX samples are all 1: oTimeout<=1, oResponse<=0, go to DONE.
- RECV:
  - Shift in 47 more bits, MSB first; run CRC7 over bits 47..8.
  - At the end, oResponse<=bits[45:8].
  - oCrc_error<=1 if transmission bit (46)≠0, OR received CRC (bits 7..1)≠computed, OR end bit (0)≠1.
  - Go to DONE.
- DONE:
  - oStrobe_out=1. oResponse, oCrc_error and oTimeout are stable while it is high; oResponse=0 for no-response commands.
  - On an edge with iAck_in=1: oStrobe_out<=0.
  - Then wait for iAck_in=0 and return to IDLE. iStrobe_in is ignored outside IDLE.
- oCmd_oe is 1 only in SEND; it is never asserted while the card may drive the line.
- Latency, acceptance to oStrobe_out:
  - No-response command: 49 cycles.
  - Otherwise: 49 + wait cycles + 48.

Test Plan:
- CMD8, arg 0x000001AA, iNo_response=0 -> oCmd_out stream = 0x48000001AA87 over 48 cycles with oCmd_oe=1. Card returns 0x08000001AA13 after 5 idle cycles -> oStrobe_out, oResponse={6'd8, 32'h000001AA}, oCrc_error=0, oTimeout=0.
- CMD0, arg 0, iNo_response=1 -> stream 0x400000000095; oStrobe_out 49 cycles after acceptance with oResponse=0. iAck_in pulse -> returns to IDLE, oIdle_out=1.
- CMD17, arg 0, card holds iCmd_in=1 -> stream 0x510000000055. oTimeout=1 after 64 wait cycles; oCrc_error=0.
- CMD8 exchange with response bit 20 flipped -> oCrc_error=1, oStrobe_out=1. Same result with end bit forced to 0.
- Handshake: hold iStrobe_in high 20 cycles -> oAck_out high the whole time and falls one edge after iStrobe_in drops. Frame bits are unaffected. A second iStrobe_in while in DONE is ignored.
- Assert iReset at cycle 20 of SEND -> oCmd_oe=0, oCmd_out=1, all outputs at reset values immediately. A new CMD8 after release transmits correctly.
